// File: rtl/enigma_pkg.sv
// Shared letter type, letter range constants and lampboard controller states.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam letter_t LETTER_NONE = 5'd0;
  localparam letter_t LETTER_A    = 5'd1;
  localparam letter_t LETTER_Z    = 5'd26;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    WAIT_FRAME,
    HOLD,
    CLEAR
  } lamp_state_t;

  function automatic logic is_letter(input letter_t l);
    return (l >= LETTER_A) && (l <= LETTER_Z);
  endfunction

endpackage

// File: rtl/enigma_frame_timer.sv
// Counts new-frame pulses after a lamp commit; expire fires on the last held frame boundary.
module enigma_frame_timer
  import enigma_pkg::*;
#(
  parameter int HOLD_FRAMES = 60
) (
  input  logic clk_pixel,
  input  logic sys_rst_pixel,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_nf,
  output logic o_expire
);

  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel || i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run && i_nf && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_expire = r_run && i_nf && (r_cnt == CNT_LAST);

endmodule

// File: rtl/enigma_lamp_ctrl.sv
// Lampboard sequencer: key -> cipher core handshake -> frame-aligned commit -> timed hold -> clear.
module enigma_lamp_ctrl
  import enigma_pkg::*;
#(
  parameter int HOLD_FRAMES = 60,
  parameter int ENC_TIMEOUT = 1024
) (
  input  logic    clk_pixel,
  input  logic    sys_rst_pixel,
  input  logic    nf_in,
  input  logic    key_valid_in,
  input  letter_t key_letter_in,
  output logic    key_ready_out,
  output logic    enc_req_out,
  output letter_t enc_letter_out,
  input  logic    enc_done_in,
  input  letter_t enc_letter_in,
  output letter_t orig_letter_out,
  output letter_t code_letter_out,
  output logic    lamp_on_out,
  output logic    err_out
);

  localparam int TO_W = $clog2(ENC_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENC_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  lamp_state_t     r_state;
  lamp_state_t     w_state_nxt;
  logic [TO_W-1:0] r_tcnt;
  letter_t         r_pend_orig;
  letter_t         r_pend_code;

  logic w_accept;
  logic w_key_ok;
  logic w_launch;
  logic w_capture;
  logic w_commit;
  logic w_blank;
  logic w_err;
  logic w_expire;
  logic w_tmr_clear;

  assign w_accept    = key_valid_in && key_ready_out;
  assign w_key_ok    = is_letter(key_letter_in);
  assign w_tmr_clear = (r_state == HOLD) && (w_state_nxt != HOLD);

  enigma_frame_timer #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_frame_timer (
    .clk_pixel    (clk_pixel),
    .sys_rst_pixel(sys_rst_pixel),
    .i_start      (w_commit),
    .i_clear      (w_tmr_clear),
    .i_nf         (nf_in),
    .o_expire     (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_blank     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_key_ok) begin
            w_launch    = 1'b1;
            w_state_nxt = ENCODE;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ENCODE: begin
        // A done pulse beats a timeout landing in the same cycle.
        if (enc_done_in) begin
          if (is_letter(enc_letter_in)) begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT_FRAME;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = CLEAR;
          end
        end else if (r_tcnt == TO_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = CLEAR;
        end
      end
      WAIT_FRAME: begin
        if (nf_in) begin
          w_commit    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A new key keeps the old lamp lit until its own result commits.
        if (w_accept && w_key_ok) begin
          w_launch    = 1'b1;
          w_state_nxt = ENCODE;
        end else begin
          w_err = w_accept;
          if (w_expire) begin
            w_blank     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      CLEAR: begin
        if (nf_in) begin
          w_blank     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) begin
      r_state         <= IDLE;
      r_tcnt          <= '0;
      key_ready_out   <= 1'b0;
      enc_req_out     <= 1'b0;
      enc_letter_out  <= LETTER_NONE;
      orig_letter_out <= LETTER_NONE;
      code_letter_out <= LETTER_NONE;
      lamp_on_out     <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      key_ready_out <= (w_state_nxt == IDLE) || (w_state_nxt == HOLD);
      enc_req_out   <= (w_state_nxt == ENCODE);
      err_out       <= w_err;
      if ((r_state == ENCODE) && (w_state_nxt == ENCODE)) begin
        if (r_tcnt != '1) r_tcnt <= r_tcnt + TO_ONE;
      end else begin
        r_tcnt <= '0;
      end
      if (w_launch) enc_letter_out <= key_letter_in;
      if (w_commit) begin
        orig_letter_out <= r_pend_orig;
        code_letter_out <= r_pend_code;
        lamp_on_out     <= 1'b1;
      end else if (w_blank) begin
        orig_letter_out <= LETTER_NONE;
        code_letter_out <= LETTER_NONE;
        lamp_on_out     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (w_capture) begin
      r_pend_orig <= enc_letter_out;
      r_pend_code <= enc_letter_in;
    end
  end

endmodule

// File: tb/tb_enigma_lamp_ctrl.sv
// Scoreboard bench for enigma_lamp_ctrl: display changes and error pulses are matched against queued expectations.
module tb_enigma_lamp_ctrl;

  logic       clk_pixel = 1'b0;
  logic       sys_rst_pixel = 1'b1;
  logic       nf_in = 1'b0;
  logic       key_valid_in = 1'b0;
  logic [4:0] key_letter_in = 5'd0;
  logic       key_ready_out;
  logic       enc_req_out;
  logic [4:0] enc_letter_out;
  logic       enc_done_in = 1'b0;
  logic [4:0] enc_letter_in = 5'd0;
  logic [4:0] orig_letter_out;
  logic [4:0] code_letter_out;
  logic       lamp_on_out;
  logic       err_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [10:0] exp_disp_q[$];
  int          exp_err_q[$];
  logic [10:0] prev_disp = '0;

  enigma_lamp_ctrl #(
    .HOLD_FRAMES(3),
    .ENC_TIMEOUT(16)
  ) dut (
    .clk_pixel      (clk_pixel),
    .sys_rst_pixel  (sys_rst_pixel),
    .nf_in          (nf_in),
    .key_valid_in   (key_valid_in),
    .key_letter_in  (key_letter_in),
    .key_ready_out  (key_ready_out),
    .enc_req_out    (enc_req_out),
    .enc_letter_out (enc_letter_out),
    .enc_done_in    (enc_done_in),
    .enc_letter_in  (enc_letter_in),
    .orig_letter_out(orig_letter_out),
    .code_letter_out(code_letter_out),
    .lamp_on_out    (lamp_on_out),
    .err_out        (err_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // nf_in is high during every window whose cycle number is a multiple of 100.
  task automatic tick();
    @(posedge clk_pixel);
    #1;
    cyc++;
    nf_in = (cyc % 100 == 0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tick_to(input int m);
    do tick(); while (cyc % 100 != m);
  endtask

  task automatic press(input logic [4:0] l);
    key_valid_in  = 1'b1;
    key_letter_in = l;
    tick();
    key_valid_in  = 1'b0;
    key_letter_in = 5'd0;
  endtask

  task automatic core_done(input logic [4:0] l);
    enc_done_in   = 1'b1;
    enc_letter_in = l;
    tick();
    enc_done_in   = 1'b0;
    enc_letter_in = 5'd0;
  endtask

  always @(negedge clk_pixel) begin : monitor
    logic [10:0] cur;
    cur = {lamp_on_out, orig_letter_out, code_letter_out};
    if (cur !== prev_disp) begin
      if (exp_disp_q.size() == 0) chk("disp_unexpected", cur, prev_disp);
      else chk("disp", cur, exp_disp_q.pop_front());
      prev_disp = cur;
    end
    if (err_out === 1'b1) begin
      if (exp_err_q.size() == 0) chk("err_unexpected", err_out, 0);
      else chk("err_cycle", cyc, exp_err_q.pop_front());
    end
  end

  initial begin : stim
    int hi;

    // Reset
    tick_n(3);
    chk("rst_ready", key_ready_out, 0);
    chk("rst_req", enc_req_out, 0);
    chk("rst_enc_letter", enc_letter_out, 0);
    chk("rst_lamp", lamp_on_out, 0);
    chk("rst_code", code_letter_out, 0);
    chk("rst_err", err_out, 0);
    sys_rst_pixel = 1'b0;
    tick();
    chk("ready_after_rst", key_ready_out, 1);

    // Basic key A -> 20, held for three frame boundaries
    press(5'd1);
    chk("basic_req", enc_req_out, 1);
    chk("basic_enc_letter", enc_letter_out, 1);
    chk("basic_busy", key_ready_out, 0);
    tick_n(4);
    chk("basic_req_held", enc_req_out, 1);
    core_done(5'd20);
    chk("basic_req_drop", enc_req_out, 0);
    exp_disp_q.push_back({1'b1, 5'd1, 5'd20});
    tick_to(0);
    tick();
    chk("basic_lamp", lamp_on_out, 1);
    chk("basic_code", code_letter_out, 20);
    exp_disp_q.push_back(11'd0);
    for (int f = 1; f <= 3; f++) begin
      tick_to(0);
      tick();
      chk("basic_hold_lamp", lamp_on_out, (f < 3) ? 1 : 0);
    end
    chk("basic_clear_ready", key_ready_out, 1);

    // Invalid keys 0 and 27
    exp_err_q.push_back(cyc + 1);
    press(5'd0);
    chk("inv0_err", err_out, 1);
    chk("inv0_req", enc_req_out, 0);
    tick();
    chk("inv0_err_pulse", err_out, 0);
    exp_err_q.push_back(cyc + 1);
    press(5'd27);
    chk("inv27_req", enc_req_out, 0);
    tick();
    chk("inv_lamp", lamp_on_out, 0);

    // Timeout with a silent core
    exp_err_q.push_back(cyc + 17);
    press(5'd5);
    hi = 0;
    while (enc_req_out && hi < 40) begin
      hi++;
      tick();
    end
    chk("timeout_req_cycles", hi, 16);
    chk("timeout_err", err_out, 1);
    chk("timeout_busy", key_ready_out, 0);
    tick_to(0);
    chk("clear_waits_nf", key_ready_out, 0);
    tick();
    chk("clear_idle_ready", key_ready_out, 1);
    chk("clear_code", code_letter_out, 0);

    // Preempt: new key on the frame boundary that would have cleared lamp 20
    press(5'd1);
    tick_n(3);
    core_done(5'd20);
    exp_disp_q.push_back({1'b1, 5'd1, 5'd20});
    tick_to(0);
    tick();
    tick_to(0);
    tick();
    tick_to(0);
    tick();
    tick_to(0);
    press(5'd2);
    chk("pre_req", enc_req_out, 1);
    chk("pre_lamp_kept", lamp_on_out, 1);
    chk("pre_code_kept", code_letter_out, 20);
    tick_n(3);
    core_done(5'd9);
    chk("pre_code_before_nf", code_letter_out, 20);
    exp_disp_q.push_back({1'b1, 5'd2, 5'd9});
    tick_to(0);
    tick();
    chk("pre_code_new", code_letter_out, 9);
    exp_disp_q.push_back(11'd0);
    for (int f = 1; f <= 3; f++) begin
      tick_to(0);
      tick();
      chk("pre_hold_lamp", lamp_on_out, (f < 3) ? 1 : 0);
    end

    // done and nf_in in the same cycle: commit waits for the next nf_in
    tick_to(95);
    press(5'd3);
    tick_to(0);
    core_done(5'd7);
    chk("sim_req_drop", enc_req_out, 0);
    chk("sim_lamp_off", lamp_on_out, 0);
    tick_n(5);
    chk("sim_code_wait", code_letter_out, 0);
    exp_disp_q.push_back({1'b1, 5'd3, 5'd7});
    tick_to(0);
    tick();
    chk("sim_code", code_letter_out, 7);
    chk("sim_orig", orig_letter_out, 3);

    // Reset while encoding; a late done is ignored
    press(5'd4);
    tick_n(2);
    chk("rst_mid_req", enc_req_out, 1);
    exp_disp_q.push_back(11'd0);
    sys_rst_pixel = 1'b1;
    tick();
    chk("rst_mid_req_drop", enc_req_out, 0);
    chk("rst_mid_enc_letter", enc_letter_out, 0);
    chk("rst_mid_lamp", lamp_on_out, 0);
    chk("rst_mid_ready", key_ready_out, 0);
    sys_rst_pixel = 1'b0;
    tick();
    core_done(5'd11);
    chk("late_done_req", enc_req_out, 0);
    chk("late_done_ready", key_ready_out, 1);
    tick_to(0);
    tick();
    chk("late_done_lamp", lamp_on_out, 0);
    chk("late_done_code", code_letter_out, 0);

    tick_n(2);
    chk("disp_pending", exp_disp_q.size(), 0);
    chk("err_pending", exp_err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
